// File: rtl/lcd_pkg.sv
// Shared types for the LCD window controller: command codes, FSM states, width helper.
package lcd_pkg;

  typedef enum logic [2:0] {
    CMD_REFRESH = 3'd0,
    CMD_LOAD    = 3'd1,
    CMD_RIGHT   = 3'd2,
    CMD_LEFT    = 3'd3,
    CMD_UP      = 3'd4,
    CMD_DOWN    = 3'd5,
    CMD_MIRROR  = 3'd6
  } lcd_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_OUT
  } lcd_state_e;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/lcd_win_addr.sv
// Combinational window-pixel address: (oy+r)*IMG_W + ox + c', with optional column reversal.
module lcd_win_addr #(
  parameter int IMG_W = 6,
  parameter int WIN   = 3,
  parameter int AW    = 6,
  parameter int OXW   = 2,
  parameter int OYW   = 2,
  parameter int CW    = 2
) (
  input  logic [OXW-1:0] ox,
  input  logic [OYW-1:0] oy,
  input  logic [CW-1:0]  r_cnt,
  input  logic [CW-1:0]  c_cnt,
  input  logic           mirror,
  output logic [AW-1:0]  addr
);

  logic [CW-1:0] c_eff;

  always_comb begin
    c_eff = mirror ? (CW'(WIN - 1) - c_cnt) : c_cnt;
    addr  = (AW'(oy) + AW'(r_cnt)) * AW'(IMG_W) + AW'(ox) + AW'(c_eff);
  end

endmodule

// File: rtl/lcd_win_ctrl.sv
// LCD window controller: serial image load, movable WIN x WIN window, row-major window stream.
// Optional horizontal mirror (cmd 6) built only when LCD_WIN_MIRROR_EN is defined.
module lcd_win_ctrl
  import lcd_pkg::*;
#(
  parameter int IMG_W = 6,
  parameter int IMG_H = 6,
  parameter int WIN   = 3,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] datain,
  input  logic [2:0]    cmd,
  input  logic          cmd_valid,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  output logic          busy
);

  localparam int N   = IMG_W * IMG_H;
  localparam int AW  = clog2_min1(N);
  localparam int OXW = clog2_min1(IMG_W - WIN + 1);
  localparam int OYW = clog2_min1(IMG_H - WIN + 1);
  localparam int CW  = clog2_min1(WIN);
  localparam logic [OXW-1:0] OX_MAX = OXW'(IMG_W - WIN);
  localparam logic [OYW-1:0] OY_MAX = OYW'(IMG_H - WIN);
  localparam logic [OXW-1:0] OX_CTR = OXW'((IMG_W - WIN) / 2);
  localparam logic [OYW-1:0] OY_CTR = OYW'((IMG_H - WIN) / 2);

  lcd_state_e     state, state_nxt;
  logic [AW-1:0]  ld_cnt, rd_addr;
  logic [CW-1:0]  r_cnt, c_cnt;
  logic [OXW-1:0] ox;
  logic [OYW-1:0] oy;
  logic [2:0]     cmd_q;
  logic           out_done, mirror, last_ld;
  logic [DW-1:0]  ram [N];

  assign busy    = (state != ST_IDLE);
  assign last_ld = (ld_cnt == AW'(N - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (cmd_valid) begin
          case (cmd)
            CMD_LOAD:                               state_nxt = ST_LOAD;
            CMD_RIGHT, CMD_LEFT, CMD_UP, CMD_DOWN:  state_nxt = ST_SHIFT;
            default:                                state_nxt = ST_OUT;
          endcase
        end
      ST_LOAD:  if (last_ld) state_nxt = ST_OUT;
      ST_SHIFT: state_nxt = ST_OUT;
      ST_OUT:   if (out_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The image RAM is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (state == ST_LOAD) ram[ld_cnt] <= datain;
  end

`ifdef LCD_WIN_MIRROR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mirror <= 1'b0;
    else if (state == ST_IDLE && cmd_valid && cmd == CMD_MIRROR)
      mirror <= ~mirror;
    else if (state == ST_LOAD && last_ld)
      mirror <= 1'b0;
  end
`else
  assign mirror = 1'b0;
`endif

  lcd_win_addr #(
    .IMG_W(IMG_W), .WIN(WIN), .AW(AW), .OXW(OXW), .OYW(OYW), .CW(CW)
  ) u_addr (
    .ox(ox), .oy(oy), .r_cnt(r_cnt), .c_cnt(c_cnt), .mirror(mirror), .addr(rd_addr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ox           <= '0;
      oy           <= '0;
      ld_cnt       <= '0;
      r_cnt        <= '0;
      c_cnt        <= '0;
      out_done     <= 1'b0;
      cmd_q        <= '0;
      dataout      <= '0;
      output_valid <= 1'b0;
    end else begin
      output_valid <= 1'b0;
      case (state)
        ST_IDLE:
          if (cmd_valid) begin
            cmd_q  <= cmd;
            ld_cnt <= '0;
          end
        ST_LOAD: begin
          ld_cnt <= ld_cnt + 1'b1;
          if (last_ld) begin
            ld_cnt <= '0;
            ox     <= OX_CTR;
            oy     <= OY_CTR;
          end
        end
        ST_SHIFT:
          case (cmd_q)
            CMD_RIGHT: if (ox != OX_MAX) ox <= ox + 1'b1;
            CMD_LEFT:  if (ox != '0)     ox <= ox - 1'b1;
            CMD_UP:    if (oy != '0)     oy <= oy - 1'b1;
            CMD_DOWN:  if (oy != OY_MAX) oy <= oy + 1'b1;
            default: ;
          endcase
        ST_OUT:
          if (!out_done) begin
            dataout      <= ram[rd_addr];
            output_valid <= 1'b1;
            if (c_cnt == CW'(WIN - 1)) begin
              c_cnt <= '0;
              if (r_cnt == CW'(WIN - 1)) begin
                r_cnt    <= '0;
                out_done <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else begin
              c_cnt <= c_cnt + 1'b1;
            end
          end else begin
            out_done <= 1'b0;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Self-checking bench for lcd_win_ctrl: directed scenarios plus random commands against a
// behavioural image/origin model. Honors LCD_WIN_MIRROR_EN for the expected mirror behaviour.
module tb_lcd_win_ctrl;
  localparam int IMG_W = 6, IMG_H = 6, WIN = 3, DW = 8;
  localparam int N = IMG_W * IMG_H;

  logic          clk = 1'b0, reset = 1'b1;
  logic [DW-1:0] datain = '0;
  logic [2:0]    cmd = '0;
  logic          cmd_valid = 1'b0;
  logic [DW-1:0] dataout;
  logic          output_valid, busy;

  int compared = 0, mism = 0;
  int img [N];
  int load_buf [N];
  int mox = 0, moy = 0;
  bit mmir = 1'b0;

  lcd_win_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .DW(DW)) dut (
    .clk(clk), .reset(reset), .datain(datain), .cmd(cmd), .cmd_valid(cmd_valid),
    .dataout(dataout), .output_valid(output_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_px(input int k);
    int r, c;
    r = k / WIN;
    c = k % WIN;
    if (mmir) c = WIN - 1 - c;
    return img[(moy + r) * IMG_W + mox + c];
  endfunction

  task automatic model_cmd(input int c);
    case (c)
      1: begin
        foreach (img[i]) img[i] = load_buf[i];
        mox = (IMG_W - WIN) / 2;
        moy = (IMG_H - WIN) / 2;
        mmir = 1'b0;
      end
      2: if (mox < IMG_W - WIN) mox++;
      3: if (mox > 0) mox--;
      4: if (moy > 0) moy--;
      5: if (moy < IMG_H - WIN) moy++;
`ifdef LCD_WIN_MIRROR_EN
      6: mmir = !mmir;
`endif
      default: ;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the accept edge; lat0 = edges already consumed since accept.
  task automatic collect(input int c, input int lat0);
    int lat, exp_lat;
    exp_lat = (c == 1) ? N + 1 : (c >= 2 && c <= 5) ? 2 : 1;
    lat = lat0;
    while (output_valid !== 1'b1 && lat < N + 20) begin
      tick();
      lat++;
    end
    chk($sformatf("latency_cmd%0d", c), lat, exp_lat);
    for (int k = 0; k < WIN * WIN; k++) begin
      chk($sformatf("pixel_cmd%0d_k%0d", c, k), dataout, exp_px(k));
      chk($sformatf("valid_cmd%0d_k%0d", c, k), output_valid, 1);
      chk($sformatf("busy_cmd%0d_k%0d", c, k), busy, 1);
      tick();
    end
    chk($sformatf("valid_drop_cmd%0d", c), output_valid, 0);
    chk($sformatf("busy_drop_cmd%0d", c), busy, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    chk("idle_wait", busy, 0);
  endtask

  task automatic run_cmd(input int c);
    int lat = 0;
    wait_idle();
    cmd = 3'(c);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk($sformatf("busy_rise_cmd%0d", c), busy, 1);
    if (c == 1) begin
      for (int i = 0; i < N; i++) begin
        datain = DW'(load_buf[i]);
        tick();
        lat++;
      end
    end
    model_cmd(c);
    collect(c, lat);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dataout", dataout, 0);
    chk("rst_valid", output_valid, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // Directed image 0..35, centred window, then boundary walks.
    foreach (load_buf[i]) load_buf[i] = i;
    run_cmd(1);
    repeat (3) run_cmd(2);
    repeat (2) run_cmd(3);
    repeat (2) run_cmd(4);
    repeat (4) run_cmd(5);
    repeat (2) run_cmd(4);
    repeat (2) run_cmd(6);
    run_cmd(7);

    // Random image, then cmd_valid held with RIGHT through a REFRESH output.
    foreach (load_buf[i]) load_buf[i] = int'($urandom_range(0, 255));
    run_cmd(1);
    wait_idle();
    cmd = 3'd0;
    cmd_valid = 1'b1;
    tick();
    chk("hold_busy_rise", busy, 1);
    cmd = 3'd2;
    model_cmd(0);
    collect(0, 0);
    tick();
    chk("hold_accept", busy, 1);
    cmd_valid = 1'b0;
    model_cmd(2);
    collect(2, 0);
    run_cmd(0);

    for (int i = 0; i < 25; i++) run_cmd(int'($urandom_range(0, 7)));

    // Asynchronous reset in the 4th output cycle.
    wait_idle();
    cmd = 3'd0;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    begin
      int n = 0;
      while (output_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      chk("rstmid_out_start", output_valid, 1);
    end
    repeat (3) tick();
    chk("rstmid_pre_valid", output_valid, 1);
    reset = 1'b1;
    #1;
    chk("rstmid_dataout", dataout, 0);
    chk("rstmid_valid", output_valid, 0);
    chk("rstmid_busy", busy, 0);
    #2;
    reset = 1'b0;
    tick();
    mox = 0;
    moy = 0;
    mmir = 1'b0;
    run_cmd(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
